ahb_traffic_gen: RTL

- Synthesisable AHB-Lite master traffic generator that sits in front of the AHB2APB bridge.
- Replaces the hand-written write/read stimulus tasks with a parametrised engine that issues N single transfers with pseudo-random inter-transfer idle delay.
- Supports write, read-check and write-then-readback-check modes, and reports mismatch and error counts.
- Usable in simulation and in FPGA bring-up.

---
 rtl/ahb_traffic_gen_if.sv | 25 ++
 rtl/ahb_traffic_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ahb_traffic_gen_if.sv
// rtl/ahb_traffic_gen_if.sv - AHB-Lite single-master bus bundle for the traffic generator
interface ahb_traffic_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_traffic_gen.sv
// rtl/ahb_traffic_gen.sv - AHB-Lite master issuing N single transfers with random idle gaps
module ahb_traffic_gen #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 8,
  parameter int          DLY_WIDTH  = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [31:0] PATTERN    = 32'h5A5A_0000
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  nums,
  input  logic [DLY_WIDTH-1:0]  max_delay,
  ahb_traffic_gen_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);
  localparam int                    BYTES = DATA_WIDTH / 8;
  localparam logic [2:0]            HSIZE = 3'($clog2(BYTES));
  localparam logic [DATA_WIDTH-1:0] PAT   = PATTERN[DATA_WIDTH-1:0];

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, base_q;
  logic [CNT_WIDTH-1:0]  idx_q, nums_q, mis_q, err_q;
  logic [DLY_WIDTH-1:0]  maxd_q, dly_q, dly_new;
  logic [DLY_WIDTH:0]    dly_div;
  logic [1:0]            mode_q;
  logic                  pass_wr_q, err_seen_q, done_q;
  logic [15:0]           lfsr_q;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  start_ok, last_xfer, second_pass;

  assign data_i      = PAT ^ DATA_WIDTH'(idx_q);
  assign start_ok    = (state_q == S_IDLE) && start && !done_q;
  assign last_xfer   = ({1'b0, idx_q} + (CNT_WIDTH+1)'(1)) >= {1'b0, nums_q};
  assign second_pass = (mode_q == 2'b10) && pass_wr_q;

  // In IDLE the run parameters are not latched yet, so the first gap uses the live input.
  assign dly_div = {1'b0, (state_q == S_IDLE) ? max_delay : maxd_q} + (DLY_WIDTH+1)'(1);
  assign dly_new = DLY_WIDTH'({1'b0, lfsr_q[DLY_WIDTH-1:0]} % dly_div);

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok)
                 state_d = (nums == '0) ? S_DONE : ((dly_new == '0) ? S_ADDR : S_DELAY);
      S_DELAY: if (dly_q == DLY_WIDTH'(1)) state_d = S_ADDR;
      S_ADDR:  if (bus.hready) state_d = S_DATA;
      S_DATA:  if (bus.hready) begin
                 if (!last_xfer || second_pass)
                   state_d = (dly_new == '0) ? S_ADDR : S_DELAY;
                 else
                   state_d = S_DONE;
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.htrans   = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    bus.hwrite   = (state_q == S_ADDR) && pass_wr_q;
    bus.haddr    = addr_q;
    bus.hwdata   = ((state_q == S_DATA) && pass_wr_q) ? data_i : '0;
    bus.hsize    = HSIZE;
    bus.hburst   = 3'b000;
    busy         = (state_q != S_IDLE);
    done         = done_q;
    mismatch_cnt = mis_q;
    err_cnt      = err_q;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_q     <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      nums_q     <= '0;
      mis_q      <= '0;
      err_q      <= '0;
      maxd_q     <= '0;
      dly_q      <= '0;
      mode_q     <= 2'b00;
      pass_wr_q  <= 1'b0;
      err_seen_q <= 1'b0;
      done_q     <= 1'b0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      done_q <= (state_q == S_DONE);
      if (state_q != S_IDLE)
        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (state_q == S_DELAY)
        dly_q <= dly_q - DLY_WIDTH'(1);
      else if (state_d == S_DELAY)
        dly_q <= dly_new;
      case (state_q)
        S_IDLE: if (start_ok) begin
          base_q     <= base_addr;
          addr_q     <= base_addr;
          nums_q     <= nums;
          maxd_q     <= max_delay;
          mode_q     <= mode;
          idx_q      <= '0;
          mis_q      <= '0;
          err_q      <= '0;
          err_seen_q <= 1'b0;
          pass_wr_q  <= (mode != 2'b01);
        end
        S_DATA: begin
          // An ERROR response is counted on its first cycle only and never compared.
          if (bus.hresp && !bus.hready && !err_seen_q) begin
            err_seen_q <= 1'b1;
            if (err_q != '1) err_q <= err_q + CNT_WIDTH'(1);
          end
          if (bus.hready) begin
            err_seen_q <= 1'b0;
            if (!pass_wr_q && !bus.hresp && !err_seen_q && (bus.hrdata != data_i) && (mis_q != '1))
              mis_q <= mis_q + CNT_WIDTH'(1);
            if (!last_xfer) begin
              idx_q  <= idx_q + CNT_WIDTH'(1);
              addr_q <= addr_q + ADDR_WIDTH'(BYTES);
            end else if (second_pass) begin
              pass_wr_q <= 1'b0;
              idx_q     <= '0;
              addr_q    <= base_q;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
